// File: rtl/sram_march_bist.sv
// March C- built-in self-test sequencer for one single-port SRAM macro.
// Issues one macro op per cycle and scores reads through a latency-matched compare pipe.
module sram_march_bist #(
   parameter int ADDR_WIDTH   = 8,
   parameter int DATA_WIDTH   = 32,
   parameter int WMASK_WIDTH  = 4,
   parameter int READ_LATENCY = 1,
   parameter int ERR_WIDTH    = 16
) (
   input  logic                   wb_clock,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   abort,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [2:0]             element,
   output logic [ERR_WIDTH-1:0]   err_count,
   output logic [ADDR_WIDTH-1:0]  first_fail_addr,
   output logic [DATA_WIDTH-1:0]  first_fail_data,
   output logic [2:0]             first_fail_element,
   output logic                   sram_csb,
   output logic                   sram_web,
   output logic [WMASK_WIDTH-1:0] sram_wmask,
   output logic [ADDR_WIDTH-1:0]  sram_addr,
   output logic [DATA_WIDTH-1:0]  sram_din,
   input  logic [DATA_WIDTH-1:0]  sram_dout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;
   localparam logic [2:0] LAST_DRAIN = 3'(READ_LATENCY - 1);
   localparam int         LT = READ_LATENCY - 1;

   logic [1:0]            state_q, state_d;
   logic [2:0]            elem_q, elem_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  wr_q, wr_d;
   logic [2:0]            drain_q, drain_d;
   logic [ERR_WIDTH-1:0]  err_q, err_d;
   logic [ADDR_WIDTH-1:0] ff_addr_q, ff_addr_d;
   logic [DATA_WIDTH-1:0] ff_data_q, ff_data_d;
   logic [2:0]            ff_elem_q, ff_elem_d;

   logic                  rd_vld_q  [READ_LATENCY];
   logic                  rd_exp_q  [READ_LATENCY];
   logic [ADDR_WIDTH-1:0] rd_addr_q [READ_LATENCY];
   logic [2:0]            rd_elem_q [READ_LATENCY];

   logic       running, busy_w, go, kill, issue_rd, is_wr;
   logic       has_rd, has_wr, desc, addr_end, wr_bg, rd_bg, miscmp;
   logic [2:0] elem_nx;

   assign running  = (state_q == S_RUN);
   assign busy_w   = running || (state_q == S_DRAIN);
   assign go       = !busy_w && start && !abort;
   assign kill     = busy_w && abort;
   assign has_rd   = (elem_q != 3'd0);
   assign has_wr   = (elem_q != 3'd5);
   assign desc     = (elem_q == 3'd3) || (elem_q == 3'd4);
   assign addr_end = desc ? (addr_q == '0) : (addr_q == '1);
   assign elem_nx  = elem_q + 3'd1;
   assign wr_bg    = (elem_q == 3'd1) || (elem_q == 3'd3);
   assign rd_bg    = (elem_q == 3'd2) || (elem_q == 3'd4);
   assign issue_rd = running && !wr_q;
   assign is_wr    = running && wr_q;
   assign miscmp   = rd_vld_q[LT] && (sram_dout != {DATA_WIDTH{rd_exp_q[LT]}});

   // Sequencer: wr_q selects the write half of a read/write pair at one address.
   always_comb begin
      state_d = state_q;
      elem_d  = elem_q;
      addr_d  = addr_q;
      wr_d    = wr_q;
      drain_d = drain_q;
      if (go) begin
         state_d = S_RUN;
         elem_d  = 3'd0;
         addr_d  = '0;
         wr_d    = 1'b1;
      end else if (kill) begin
         state_d = S_IDLE;
      end else if (running) begin
         if (!wr_q && has_wr) begin
            wr_d = 1'b1;
         end else if (addr_end) begin
            if (elem_q == 3'd5) begin
               state_d = S_DRAIN;
               drain_d = 3'd0;
            end else begin
               elem_d = elem_nx;
               addr_d = ((elem_nx == 3'd3) || (elem_nx == 3'd4)) ? '1 : '0;
               wr_d   = 1'b0;
            end
         end else begin
            addr_d = desc ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
            wr_d   = !has_rd;
         end
      end else if (state_q == S_DRAIN) begin
         if (drain_q == LAST_DRAIN) state_d = S_DONE;
         else drain_d = drain_q + 3'd1;
      end
   end

   always_comb begin
      err_d     = err_q;
      ff_addr_d = ff_addr_q;
      ff_data_d = ff_data_q;
      ff_elem_d = ff_elem_q;
      if (go) begin
         err_d     = '0;
         ff_addr_d = '0;
         ff_data_d = '0;
         ff_elem_d = 3'd0;
      end else if (miscmp && !kill) begin
         if (err_q != '1) err_d = err_q + ERR_WIDTH'(1);
         if (err_q == '0) begin
            ff_addr_d = rd_addr_q[LT];
            ff_data_d = sram_dout;
            ff_elem_d = rd_elem_q[LT];
         end
      end
   end

   always_ff @(posedge wb_clock) begin
      if (reset) begin
         state_q   <= S_IDLE;
         elem_q    <= 3'd0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         drain_q   <= 3'd0;
         err_q     <= '0;
         ff_addr_q <= '0;
         ff_data_q <= '0;
         ff_elem_q <= 3'd0;
         for (int i = 0; i < READ_LATENCY; i++) rd_vld_q[i] <= 1'b0;
      end else begin
         state_q   <= state_d;
         elem_q    <= elem_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         drain_q   <= drain_d;
         err_q     <= err_d;
         ff_addr_q <= ff_addr_d;
         ff_data_q <= ff_data_d;
         ff_elem_q <= ff_elem_d;
         rd_vld_q[0] <= issue_rd && !kill;
         for (int i = 1; i < READ_LATENCY; i++) rd_vld_q[i] <= rd_vld_q[i-1] && !kill && !go;
      end
   end

   // Compare pipe payload: qualified by rd_vld_q, so it needs no reset.
   always_ff @(posedge wb_clock) begin
      rd_exp_q[0]  <= rd_bg;
      rd_addr_q[0] <= addr_q;
      rd_elem_q[0] <= elem_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
         rd_exp_q[i]  <= rd_exp_q[i-1];
         rd_addr_q[i] <= rd_addr_q[i-1];
         rd_elem_q[i] <= rd_elem_q[i-1];
      end
   end

   assign busy               = busy_w;
   assign done               = (state_q == S_DONE);
   assign pass               = (state_q == S_DONE) && (err_q == '0);
   assign element            = elem_q;
   assign err_count          = err_q;
   assign first_fail_addr    = ff_addr_q;
   assign first_fail_data    = ff_data_q;
   assign first_fail_element = ff_elem_q;
   assign sram_csb           = !running;
   assign sram_web           = !is_wr;
   assign sram_wmask         = is_wr ? '1 : '0;
   assign sram_addr          = running ? addr_q : '0;
   assign sram_din           = (is_wr && wr_bg) ? '1 : '0;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: two instances (latency 1 / 16-bit errors, latency 3 / 2-bit errors)
// on behavioural SRAMs with injectable stuck-at faults, scored against an algorithmic March C- model.
module tb_sram_march_bist;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset, start, abort;

   logic        busy_a, done_a, pass_a, csb_a, web_a;
   logic [2:0]  elem_a, ffe_a;
   logic [15:0] err_a;
   logic [3:0]  ffa_a, addr_a, wmask_a;
   logic [31:0] ffd_a, din_a, dout_a;

   logic        busy_b, done_b, pass_b, csb_b, web_b;
   logic [2:0]  elem_b, ffe_b;
   logic [1:0]  err_b;
   logic [3:0]  ffa_b, addr_b, wmask_b;
   logic [31:0] ffd_b, din_b, dout_b;

   sram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WMASK_WIDTH(4), .READ_LATENCY(1), .ERR_WIDTH(16)) dut_a (
      .wb_clock(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy_a), .done(done_a), .pass(pass_a), .element(elem_a), .err_count(err_a),
      .first_fail_addr(ffa_a), .first_fail_data(ffd_a), .first_fail_element(ffe_a),
      .sram_csb(csb_a), .sram_web(web_a), .sram_wmask(wmask_a), .sram_addr(addr_a),
      .sram_din(din_a), .sram_dout(dout_a));

   sram_march_bist #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .WMASK_WIDTH(4), .READ_LATENCY(3), .ERR_WIDTH(2)) dut_b (
      .wb_clock(clk), .reset(reset), .start(start), .abort(abort),
      .busy(busy_b), .done(done_b), .pass(pass_b), .element(elem_b), .err_count(err_b),
      .first_fail_addr(ffa_b), .first_fail_data(ffd_b), .first_fail_element(ffe_b),
      .sram_csb(csb_b), .sram_web(web_b), .sram_wmask(wmask_b), .sram_addr(addr_b),
      .sram_din(din_b), .sram_dout(dout_b));

   // Fault configuration shared by both memories and by the reference model.
   bit          f_en, f_all;
   int          f_addr;
   logic [31:0] f_mask, f_val;

   function automatic logic [31:0] fault_rd(input logic [31:0] d, input int a);
      if (f_en && (f_all || a == f_addr)) return (d & ~f_mask) | (f_val & f_mask);
      return d;
   endfunction

   logic [31:0] mem_a [16];
   logic [31:0] mem_b [16];
   logic [31:0] rq_a, rq_b0, rq_b1, rq_b2;
   int          ops_a = 0, ops_b = 0;
   assign dout_a = rq_a;
   assign dout_b = rq_b2;

   always @(posedge clk) begin
      if (!csb_a) begin
         ops_a++;
         if (!web_a) begin
            for (int i = 0; i < 4; i++) if (wmask_a[i]) mem_a[addr_a][8*i +: 8] = din_a[8*i +: 8];
         end else rq_a <= fault_rd(mem_a[addr_a], int'(addr_a));
      end
      if (!csb_b) begin
         ops_b++;
         if (!web_b) begin
            for (int i = 0; i < 4; i++) if (wmask_b[i]) mem_b[addr_b][8*i +: 8] = din_b[8*i +: 8];
         end else rq_b0 <= fault_rd(mem_b[addr_b], int'(addr_b));
      end
      rq_b1 <= rq_b0;
      rq_b2 <= rq_b1;
   end

   int n_checks = 0, n_errors = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: run March C- on a 16-word array with the fault applied on every read.
   function automatic void march_model(input longint cap, output longint err, output int ffa,
                                       output logic [31:0] ffd, output int ffe);
      logic [31:0] m [16];
      err = 0; ffa = 0; ffd = 0; ffe = 0;
      for (int e = 0; e < 6; e++) begin
         for (int i = 0; i < 16; i++) begin
            int a;
            logic [31:0] got, exp;
            a = (e == 3 || e == 4) ? 15 - i : i;
            if (e != 0) begin
               exp = (e == 2 || e == 4) ? 32'hFFFF_FFFF : 32'h0;
               got = fault_rd(m[a], a);
               if (got !== exp) begin
                  if (err == 0) begin ffa = a; ffd = got; ffe = e; end
                  if (err < cap) err++;
               end
            end
            if (e != 5) m[a] = (e == 1 || e == 3) ? 32'hFFFF_FFFF : 32'h0;
         end
      end
   endfunction

   logic [2:0]  elem_log [176];
   logic [3:0]  addr_log [176];
   logic        web_log  [176];
   logic [31:0] din_log  [176];
   int          base_a, base_b;

   task automatic run_both(input bit pulse_busy_start, output int da, output int db);
      @(negedge clk);
      start = 1'b1;
      base_a = ops_a; base_b = ops_b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      da = -1; db = -1;
      for (int m = 0; m < 176; m++) begin
         if (m == 0) check_val("busy_after_start", {busy_a, busy_b}, 2'b11);
         if (done_a && da < 0) da = m;
         if (done_b && db < 0) db = m;
         elem_log[m] = elem_a; addr_log[m] = addr_a; web_log[m] = web_a; din_log[m] = din_a;
         start = pulse_busy_start && (m < 150) && (m % 7 == 3);
         @(posedge clk);
         @(negedge clk);
      end
      start = 1'b0;
   endtask

   task automatic check_results(input string tag, input int da, input int db);
      longint ea, eb;
      int fa_a, fe_a, fa_b, fe_b;
      logic [31:0] fd_a, fd_b;
      march_model(65535, ea, fa_a, fd_a, fe_a);
      march_model(3, eb, fa_b, fd_b, fe_b);
      check_val({tag, "_done_cyc_a"}, da, 161);
      check_val({tag, "_done_cyc_b"}, db, 163);
      check_val({tag, "_ops_a"}, ops_a - base_a, 160);
      check_val({tag, "_ops_b"}, ops_b - base_b, 160);
      check_val({tag, "_busy"}, {busy_a, busy_b}, 2'b00);
      check_val({tag, "_err_a"}, err_a, ea);
      check_val({tag, "_err_b"}, err_b, eb);
      check_val({tag, "_pass_a"}, pass_a, ea == 0);
      check_val({tag, "_pass_b"}, pass_b, eb == 0);
      if (ea != 0) begin
         check_val({tag, "_ffa_a"}, ffa_a, fa_a);
         check_val({tag, "_ffd_a"}, ffd_a, fd_a);
         check_val({tag, "_ffe_a"}, ffe_a, fe_a);
      end
      if (eb != 0) begin
         check_val({tag, "_ffa_b"}, ffa_b, fa_b);
         check_val({tag, "_ffd_b"}, ffd_b, fd_b);
         check_val({tag, "_ffe_b"}, ffe_b, fe_b);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_busy_a"}, busy_a, 0);
      check_val({tag, "_done_a"}, done_a, 0);
      check_val({tag, "_pass_a"}, pass_a, 0);
      check_val({tag, "_elem_a"}, elem_a, 0);
      check_val({tag, "_err_a"}, err_a, 0);
      check_val({tag, "_ff_a"}, {ffa_a, ffd_a, ffe_a}, 0);
      check_val({tag, "_csb_web_a"}, {csb_a, web_a}, 2'b11);
      check_val({tag, "_wm_addr_din_a"}, {wmask_a, addr_a, din_a}, 0);
      check_val({tag, "_ctl_b"}, {busy_b, done_b, pass_b, csb_b, web_b}, 5'b00011);
      check_val({tag, "_err_b"}, err_b, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   int da, db, oa, ob;

   initial begin
      reset = 1'b1; start = 1'b0; abort = 1'b0;
      f_en = 0; f_all = 0; f_addr = 0; f_mask = 0; f_val = 0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset_outputs("rst");
      reset = 1'b0;

      // Fault-free run, including element/address sequencing on the port.
      run_both(1'b0, da, db);
      check_results("clean", da, db);
      check_val("seq_m0", {web_log[0], addr_log[0], din_log[0]}, {1'b0, 4'd0, 32'h0});
      check_val("seq_elem15_16", {elem_log[15], elem_log[16]}, {3'd0, 3'd1});
      check_val("seq_m16_rd", {web_log[16], addr_log[16]}, {1'b1, 4'd0});
      check_val("seq_elem79_80", {elem_log[79], elem_log[80]}, {3'd2, 3'd3});
      check_val("seq_m80_rd", {web_log[80], addr_log[80]}, {1'b1, 4'd15});
      check_val("seq_m81_wr", {web_log[81], addr_log[81], din_log[81]}, {1'b0, 4'd15, 32'hFFFF_FFFF});
      check_val("seq_m82_addr", addr_log[82], 4'd14);
      check_val("seq_m159_e5", {elem_log[159], addr_log[159], web_log[159]}, {3'd5, 4'd15, 1'b1});

      // Bit 0 stuck-at-1 at address 5.
      f_en = 1; f_all = 0; f_addr = 5; f_mask = 32'h1; f_val = 32'h1;
      run_both(1'b0, da, db);
      check_results("sa1", da, db);
      check_val("sa1_fixed_a", {err_a, ffa_a, ffd_a, ffe_a, pass_a}, {16'd3, 4'd5, 32'h1, 3'd1, 1'b0});

      // Whole array stuck at ones: B saturates.
      f_all = 1; f_mask = 32'hFFFF_FFFF; f_val = 32'hFFFF_FFFF;
      run_both(1'b0, da, db);
      check_results("all1", da, db);
      check_val("all1_sat_b", {err_b, ffa_b, ffe_b}, {2'd3, 4'd0, 3'd1});
      check_val("all1_err_a", err_a, 16'd48);

      // Randomised stuck-at faults.
      for (int it = 0; it < 6; it++) begin
         f_en = 1; f_all = 0;
         f_addr = $urandom_range(0, 15);
         f_mask = (it % 2 == 0) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
         f_val = $urandom;
         run_both(1'b0, da, db);
         check_results($sformatf("rnd%0d", it), da, db);
      end

      // Simultaneous start and abort while idle: start ignored.
      f_en = 0;
      @(negedge clk);
      start = 1'b1; abort = 1'b1; oa = ops_a;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      repeat (3) begin @(posedge clk); @(negedge clk); end
      check_val("start_abort_idle", {busy_a, busy_b, csb_a, csb_b}, 4'b0011);
      check_val("start_abort_ops", ops_a - oa, 0);

      // Abort mid-test, then a clean rerun.
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (50) begin @(posedge clk); @(negedge clk); end
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk);
      abort = 1'b0;
      oa = ops_a; ob = ops_b;
      check_val("abort_state_a", {csb_a, busy_a, done_a}, 3'b100);
      check_val("abort_state_b", {csb_b, busy_b, done_b}, 3'b100);
      repeat (5) begin @(posedge clk); @(negedge clk); end
      check_val("abort_no_ops", (ops_a - oa) + (ops_b - ob), 0);
      check_val("abort_done_held0", {done_a, done_b}, 2'b00);
      run_both(1'b0, da, db);
      check_results("post_abort", da, db);

      // Reset mid-test with a fault already counted, then a run with start pulses while busy.
      f_en = 1; f_all = 0; f_addr = 5; f_mask = 32'h1; f_val = 32'h1;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (29) begin @(posedge clk); @(negedge clk); end
      check_val("pre_reset_err_a", err_a, 16'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst");
      reset = 1'b0;
      oa = ops_a;
      repeat (4) begin @(posedge clk); @(negedge clk); end
      check_val("midrst_no_ops", ops_a - oa, 0);
      run_both(1'b1, da, db);
      check_results("post_reset", da, db);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
